// File: rtl/if_id_skid_register_pkg.sv
// rtl/if_id_skid_register_pkg.sv - shared constants and types for the IF/ID boundary register
//
// Purpose: instruction field bit positions, the R-type opcode, the default NOP
// encoding and the buffer occupancy type. These are shared by the skid register
// and by any decode stage that reuses instr_field_split.
// Ports: none (package).

package if_id_skid_register_pkg;

  localparam int INSTR_W = 32;

  // MIPS instruction field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int IMM_HI = 15;

  localparam logic [5:0]         OPC_RTYPE = 6'b000000;
  localparam logic [INSTR_W-1:0] NOP_ENC   = 32'h0000_0000;

  // Buffer occupancy; the encoding doubles as the entry count
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/if_id_skid_register_if.sv
// rtl/if_id_skid_register_if.sv - fetch-side and decode-side handshake bundle
//
// Purpose: groups the fetch push handshake, flush, the decode pop handshake and
// the decoded head fields of the IF/ID skid register.
// Modports:
//   slave  - the skid register: takes in_valid/in_instr/in_pc/flush/out_ready,
//            drives in_ready/out_valid/out_pc_plus4 and the decoded fields.
//   master - the environment around it (fetch + decode), opposite directions.

interface if_id_skid_register_if
  import if_id_skid_register_pkg::*;
#(
  parameter int PC_W = 32
);

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               flush;

  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc_plus4;
  logic [5:0]         out_opcode;
  logic [4:0]         out_rs;
  logic [4:0]         out_rt;
  logic [4:0]         out_rd;
  logic [4:0]         out_shamt;
  logic [5:0]         out_funct;
  logic [15:0]        out_imm16;
  logic               out_is_rtype;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc_plus4, out_opcode, out_rs, out_rt,
           out_rd, out_shamt, out_funct, out_imm16, out_is_rtype
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc_plus4, out_opcode, out_rs, out_rt,
           out_rd, out_shamt, out_funct, out_imm16, out_is_rtype
  );

endinterface

// File: rtl/if_id_skid_register_instr_field_split.sv
// rtl/if_id_skid_register_instr_field_split.sv - combinational MIPS instruction field splitter
//
// Purpose: slices a 32-bit instruction word into its MIPS fields and flags
// R-type words. Purely combinational; reusable by later decode stages.
// Ports:
//   instr     in   32  instruction word
//   opcode    out  6   instr[31:26]
//   rs        out  5   instr[25:21]
//   rt        out  5   instr[20:16]
//   rd        out  5   instr[15:11]
//   shamt     out  5   instr[10:6]
//   funct     out  6   instr[5:0]
//   imm16     out  16  instr[15:0]
//   is_rtype  out  1   opcode == 6'b000000

module instr_field_split
  import if_id_skid_register_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
  output logic [15:0]        imm16,
  output logic               is_rtype
);

  assign opcode   = instr[OPC_HI:OPC_LO];
  assign rs       = instr[RS_HI:RS_LO];
  assign rt       = instr[RT_HI:RT_LO];
  assign rd       = instr[RD_HI:RD_LO];
  assign shamt    = instr[SH_HI:SH_LO];
  assign funct    = instr[FN_HI:0];
  assign imm16    = instr[IMM_HI:0];
  assign is_rtype = (instr[OPC_HI:OPC_LO] == OPC_RTYPE);

endmodule

// File: rtl/if_id_skid_register.sv
// rtl/if_id_skid_register.sv - two-entry skid buffer at the fetch/decode boundary
//
// Purpose: accepts fetched {instr, pc} pairs with a valid/ready handshake,
// buffers up to two in FIFO order and presents the head split into fields.
// flush empties the buffer on the next edge and discards a simultaneous push.
// in_ready depends only on the stored occupancy, so there is no combinational
// path from out_ready to in_ready. A pushed word is visible one cycle later.
// Ports:
//   clk    in  1  rising-edge clock
//   reset  in  1  asynchronous active-high reset
//   bus    slave modport of if_id_skid_register_if (handshakes + head fields)

module if_id_skid_register
  import if_id_skid_register_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC,
  parameter int                 PC_W      = 32
)(
  input  logic                   clk,
  input  logic                   reset,
  if_id_skid_register_if.slave   bus
);

  occ_t               state_q, state_d;
  logic [INSTR_W-1:0] head_instr_q, head_instr_d;
  logic [INSTR_W-1:0] tail_instr_q, tail_instr_d;
  logic [PC_W-1:0]    head_pc_q, head_pc_d;
  logic [PC_W-1:0]    tail_pc_q, tail_pc_d;
  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] view_instr;

  assign bus.in_ready  = (state_q != TWO);
  assign bus.out_valid = (state_q != EMPTY);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      head_instr_q <= NOP_INSTR;
      tail_instr_q <= NOP_INSTR;
      head_pc_q    <= '0;
      tail_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      head_instr_q <= head_instr_d;
      tail_instr_q <= tail_instr_d;
      head_pc_q    <= head_pc_d;
      tail_pc_q    <= tail_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    head_instr_d = head_instr_q;
    tail_instr_d = tail_instr_q;
    head_pc_d    = head_pc_q;
    tail_pc_d    = tail_pc_q;

    if (bus.flush) begin
      // A pop in this cycle was still taken by decode; the push is dropped.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d      = ONE;
            head_instr_d = bus.in_instr;
            head_pc_d    = bus.in_pc;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d      = TWO;
            tail_instr_d = bus.in_instr;
            tail_pc_d    = bus.in_pc;
          end else if (!push && pop) begin
            state_d = EMPTY;
          end else if (push && pop) begin
            // Head leaves, the incoming word replaces it directly.
            head_instr_d = bus.in_instr;
            head_pc_d    = bus.in_pc;
          end
        end
        TWO: begin
          if (pop) begin
            state_d      = ONE;
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Stale storage is masked so an empty buffer always decodes as NOP.
  assign view_instr       = bus.out_valid ? head_instr_q : NOP_INSTR;
  assign bus.out_pc_plus4 = bus.out_valid ? (head_pc_q + PC_W'(4)) : '0;

  instr_field_split u_split (
    .instr    (view_instr),
    .opcode   (bus.out_opcode),
    .rs       (bus.out_rs),
    .rt       (bus.out_rt),
    .rd       (bus.out_rd),
    .shamt    (bus.out_shamt),
    .funct    (bus.out_funct),
    .imm16    (bus.out_imm16),
    .is_rtype (bus.out_is_rtype)
  );

endmodule

// File: tb/tb_if_id_skid_register.sv
// tb/tb_if_id_skid_register.sv - self-checking bench for if_id_skid_register

module tb_if_id_skid_register;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  int   pops_seen;
  entry_t sb[$];

  if_id_skid_register_if #(.PC_W(32)) bus ();

  if_id_skid_register #(
    .NOP_INSTR (32'h0000_0000),
    .PC_W      (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: sample handshakes at negedge, score pops, record pushes,
  // return 1 time unit after the following rising edge.
  task automatic cycle(input string tag);
    logic        do_push;
    logic        do_pop;
    entry_t      e;
    logic [48:0] got_f;
    logic [48:0] exp_f;
    @(negedge clk);
    do_push = bus.in_valid && bus.in_ready;
    do_pop  = bus.out_valid && bus.out_ready;
    if (do_pop) begin
      pops_seen++;
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL %s pop_underflow: got pop of instr %h, expected no output", tag, {bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_imm16});
      end else begin
        e = sb.pop_front();
        exp_f = {e.instr[31:26], e.instr[25:21], e.instr[20:16], e.instr[15:11],
                 e.instr[10:6], e.instr[5:0], e.instr[15:0], (e.instr[31:26] == 6'd0)};
        got_f = {bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_rd,
                 bus.out_shamt, bus.out_funct, bus.out_imm16, bus.out_is_rtype};
        if (got_f !== exp_f) begin
          tests_failed++;
          $display("FAIL %s pop_fields: got %h, expected %h (instr %h)", tag, got_f, exp_f, e.instr);
        end
        tests_run++;
        if (bus.out_pc_plus4 !== e.pc + 32'd4) begin
          tests_failed++;
          $display("FAIL %s pop_pc_plus4: got %h, expected %h", tag, bus.out_pc_plus4, e.pc + 32'd4);
        end
      end
    end
    if (bus.flush) sb.delete();
    else if (do_push) sb.push_back('{instr: bus.in_instr, pc: bus.in_pc});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.in_pc     = 32'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    #23;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_during: got out_valid=%b in_ready=%b, expected 0/1", bus.out_valid, bus.in_ready);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if ({bus.out_valid, bus.in_ready, bus.out_imm16, bus.out_is_rtype, bus.out_pc_plus4}
        !== {1'b0, 1'b1, 16'h0000, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_release: got v=%b r=%b imm=%h rt=%b pc4=%h, expected 0 1 0000 1 00000000",
               bus.out_valid, bus.in_ready, bus.out_imm16, bus.out_is_rtype, bus.out_pc_plus4);
    end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h2008_FFFF;
    bus.in_pc     = 32'h0040_0000;
    cycle("single");
    bus.in_valid = 1'b0;
    tests_run++;
    if ({bus.out_valid, bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_imm16, bus.out_is_rtype}
        !== {1'b1, 6'h08, 5'd0, 5'd8, 16'hFFFF, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_fields: got v=%b op=%h rs=%0d rt=%0d imm=%h rt=%b, expected 1 08 0 8 ffff 0",
               bus.out_valid, bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_imm16, bus.out_is_rtype);
    end
    tests_run++;
    if (bus.out_pc_plus4 !== 32'h0040_0004) begin
      tests_failed++;
      $display("FAIL single_pc_plus4: got %h, expected 00400004", bus.out_pc_plus4);
    end
    cycle("single");
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_popped: got out_valid=%b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_fill_and_drain();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h0109_5020;
    bus.in_pc     = 32'h0000_1000;
    cycle("fill");
    bus.in_instr  = 32'h8D28_0004;
    bus.in_pc     = 32'h0000_1004;
    cycle("fill");
    tests_run++;
    if (bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_full: got in_ready=%b, expected 0", bus.in_ready);
    end
    bus.in_instr = 32'hDEAD_BEEF;
    bus.in_pc    = 32'h0000_1008;
    cycle("fill");
    bus.in_valid = 1'b0;
    tests_run++;
    if ({bus.out_valid, bus.out_rd, bus.out_funct} !== {1'b1, 5'd10, 6'h20}) begin
      tests_failed++;
      $display("FAIL fill_head1: got v=%b rd=%0d funct=%h, expected 1 10 20", bus.out_valid, bus.out_rd, bus.out_funct);
    end
    bus.out_ready = 1'b1;
    cycle("drain");
    tests_run++;
    if ({bus.out_valid, bus.out_opcode, bus.out_imm16} !== {1'b1, 6'h23, 16'h0004}) begin
      tests_failed++;
      $display("FAIL fill_head2: got v=%b op=%h imm=%h, expected 1 23 0004", bus.out_valid, bus.out_opcode, bus.out_imm16);
    end
    cycle("drain");
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL fill_drained: got out_valid=%b pending=%0d, expected 0 0", bus.out_valid, sb.size());
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h2010_0001;
    bus.in_pc     = 32'h0000_2000;
    cycle("flush");
    bus.in_instr  = 32'h2011_0002;
    bus.in_pc     = 32'h0000_2004;
    cycle("flush");
    bus.in_instr  = 32'h2012_0003;
    bus.in_pc     = 32'h0000_2008;
    bus.flush     = 1'b1;
    cycle("flush");
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    tests_run++;
    if ({bus.out_valid, bus.in_ready, bus.out_opcode, bus.out_pc_plus4} !== {1'b0, 1'b1, 6'h00, 32'h0}) begin
      tests_failed++;
      $display("FAIL flush_empty: got v=%b r=%b op=%h pc4=%h, expected 0 1 00 00000000",
               bus.out_valid, bus.in_ready, bus.out_opcode, bus.out_pc_plus4);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle("flush_after");
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_stays_empty: got out_valid=%b, expected 0", bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int pops_before;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h3C01_1234;
    bus.in_pc     = 32'h0000_3000;
    cycle("b2b");
    pops_before   = pops_seen;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_instr = $urandom;
      bus.in_pc    = 32'h0000_3004 + 32'(i * 4);
      cycle("b2b");
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_steady_%0d: got out_valid=%b in_ready=%b, expected 1 1", i, bus.out_valid, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    cycle("b2b");
    bus.out_ready = 1'b0;
    tests_run++;
    if (pops_seen - pops_before != 9 || sb.size() != 0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_count: got pops=%0d pending=%0d v=%b, expected 9 0 0",
               pops_seen - pops_before, sb.size(), bus.out_valid);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h0000_0020;
    bus.in_pc     = 32'hFFFF_FFFC;
    cycle("wrap");
    tests_run++;
    if (bus.out_pc_plus4 !== 32'h0000_0000 || bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_pc_plus4: got %h v=%b, expected 00000000 1", bus.out_pc_plus4, bus.out_valid);
    end
    bus.in_instr = 32'h2008_0001;
    bus.in_pc    = 32'h0000_4000;
    cycle("wrap");
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_two: got in_ready=%b, expected 0", bus.in_ready);
    end
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    tests_run++;
    if ({bus.out_valid, bus.in_ready, bus.out_pc_plus4, bus.out_opcode} !== {1'b0, 1'b1, 32'h0, 6'h00}) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%b r=%b pc4=%h op=%h before edge, expected 0 1 00000000 00",
               bus.out_valid, bus.in_ready, bus.out_pc_plus4, bus.out_opcode);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_release: got v=%b r=%b, expected 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    pops_seen    = 0;
    test_reset();
    test_single();
    test_fill_and_drain();
    test_flush();
    test_back_to_back();
    test_wrap_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/if_id_skid_register.md
Name: if_id_skid_register

Overview:
- Fetch/decode boundary register of the MIPS-style datapath.
- Accepts fetched instruction words with a valid/ready handshake and buffers up to two of them in a skid buffer.
- Presents the head instruction split into its fields; the 16-bit immediate field feeds the 16-to-32 sign extender directly downstream.
- Decouples fetch from decode stalls and supports branch flush.

Parameters:
- NOP_INSTR, 32'h0000_0000: value driven on the field outputs while the buffer is empty; fields decode from this word.
- PC_W, 32: program-counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  buffer can accept this cycle.
- in_instr  input  32  fetched instruction word.
- in_pc  input  PC_W  address of in_instr.
- flush  input  1  discard all buffered and incoming instructions.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc_plus4  output  PC_W  head PC + 4, modulo 2^PC_W.
- out_opcode  output  6  instr[31:26].
- out_rs  output  5  instr[25:21].
- out_rt  output  5  instr[20:16].
- out_rd  output  5  instr[15:11].
- out_shamt  output  5  instr[10:6].
- out_funct  output  6  instr[5:0].
- out_imm16  output  16  instr[15:0], to sign extender num input.
- out_is_rtype  output  1  opcode == 6'b000000.

Behaviour:
- Storage: two entries {instr, pc}, head and tail. State EMPTY / ONE / TWO is held in a 2-bit count.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != 2). It is combinational from state only, not from out_ready, so there is no combinational in-to-out path.
- out_valid = (count != 0). The field outputs are decoded combinationally from the head entry. When EMPTY, the field outputs decode NOP_INSTR and out_pc_plus4 = 0.
- Zero-latency pass-through is not provided: a word pushed in cycle N is first visible on the outputs in cycle N+1.
- Transitions:
  - EMPTY, push -> ONE.
  - ONE, push only -> TWO.
  - ONE, pop only -> EMPTY.
  - ONE, push and pop -> ONE; the new word becomes head.
  - TWO, pop -> ONE; the tail moves to head. Push is impossible in TWO because in_ready = 0.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- flush has priority over everything. On the next edge count = 0, a simultaneous push is discarded, and a simultaneous pop still counts as consumed by decode. On the following cycle out_valid = 0 and in_ready = 1.
- Reset: asynchronous, takes effect immediately and independently of clk.
  - count = 0 and entry storage = NOP_INSTR / pc 0.
  - Outputs during and after reset: out_valid = 0, in_ready = 1, fields decode NOP_INSTR, out_pc_plus4 = 0.
  - Reset mid-operation loses all buffered words.
- PC arithmetic: pc + 4 wraps, e.g. 32'hFFFF_FFFC -> 32'h0000_0000.
- Data stability: while out_valid && !out_ready, the head fields are held unchanged.

Decomposition:
- Shared package holds:
  - Field bit-position constants: OPC_HI=31, OPC_LO=26, RS_HI=25, RS_LO=21, RT_HI=20, RT_LO=16, RD_HI=15, RD_LO=11, SH_HI=10, SH_LO=6, FN_HI=5, IMM_HI=15.
  - OPC_RTYPE = 6'b000000.
  - The NOP encoding.
- One natural sub-module: instr_field_split (combinational 32-bit word -> opcode/rs/rt/rd/shamt/funct/imm16/is_rtype). It is reusable by later decode stages.

Test Plan:
1. Reset release, no stimulus -> out_valid=0, in_ready=1, out_imm16=16'h0000, out_is_rtype=1, out_pc_plus4=0.
2. Push in_instr=32'h2008_FFFF, in_pc=32'h0040_0000 with out_ready=1 -> next cycle out_opcode=6'h08, out_rs=0, out_rt=8, out_imm16=16'hFFFF, out_pc_plus4=32'h0040_0004, out_is_rtype=0; popped the cycle after.
3. out_ready=0, push 32'h0109_5020 then 32'h8D28_0004 -> in_ready=0 after the second push. A third in_valid is not accepted. Releasing out_ready yields the words in order: first out_rd=10, out_funct=6'h20; then out_opcode=6'h23, out_imm16=16'h0004.
4. Buffer in state TWO, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1; the flushed and incoming words never appear.
5. In state ONE, push and pop in the same cycle for 8 back-to-back words -> count stays 1 and each word appears exactly once, in order.
6. in_pc=32'hFFFF_FFFC -> out_pc_plus4=32'h0000_0000. Asserting reset asynchronously while in state TWO -> out_valid drops before the next clk edge.
